// File: rtl/cr_pkg.sv
// Shared constants for the countdown timer: field select codes, FSM encoding and BCD limits.
// Pure declarations; no latency or backpressure involved.
package cr_pkg;

   localparam logic [1:0] SEL_SEG  = 2'd0;
   localparam logic [1:0] SEL_MIN  = 2'd1;
   localparam logic [1:0] SEL_HORA = 2'd2;
   localparam logic [1:0] SEL_RSVD = 2'd3;

   localparam logic [7:0] HR_MAX_DEF  = 8'h23;
   localparam logic [7:0] MIN_MAX_DEF = 8'h59;
   localparam logic [7:0] SEC_MAX_DEF = 8'h59;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Two valid BCD digits and no larger than the field limit.
   function automatic logic bcd_ok(input logic [7:0] d, input logic [7:0] max);
      return (d[7:4] <= 4'd9) && (d[3:0] <= 4'd9) && (d <= max);
   endfunction

endpackage

// File: rtl/bcd_dec2.sv
// Two-digit BCD decrement; 00 wraps to the supplied value and raises borrow.
// Purely combinational, zero latency, no flow control.
module bcd_dec2 (
   input  logic [7:0] val,
   input  logic [7:0] wrap,
   output logic [7:0] res,
   output logic       borrow
);

   always_comb begin
      res    = val;
      borrow = 1'b0;
      if (val == 8'h00) begin
         res    = wrap;
         borrow = 1'b1;
      end else if (val[3:0] == 4'd0) begin
         res = {val[7:4] - 4'd1, 4'd9};
      end else begin
         res = {val[7:4], val[3:0] - 4'd1};
      end
   end

endmodule

// File: rtl/cr_timer_reg.sv
// hh:mm:ss BCD countdown timer with per-field load, 1 Hz tick and done/ring flags.
// Loads and ticks land on the sampling edge (1 cycle); no backpressure, loads always accepted or flagged.
module cr_timer_reg
   import cr_pkg::*;
#(
   parameter logic [7:0] HR_MAX  = HR_MAX_DEF,
   parameter logic [7:0] MIN_MAX = MIN_MAX_DEF,
   parameter logic [7:0] SEC_MAX = SEC_MAX_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       EN,
   input  logic [1:0] sel,
   input  logic [7:0] din,
   input  logic       run,
   output logic [7:0] dato_cr_seg,
   output logic [7:0] dato_cr_min,
   output logic [7:0] dato_cr_hora,
   output logic       done,
   output logic       ring,
   output logic       load_err
);

   state_t     state, state_nxt;
   logic [7:0] seg_nxt, min_nxt, hora_nxt;
   logic [7:0] seg_dec, min_dec, hora_dec;
   logic       seg_brw, min_brw, hora_brw;
   logic       ld_ok, ld_bad, dec_en, time_zero, dec_zero;
   logic       ring_nxt;

   bcd_dec2 u_dec_seg  (.val(dato_cr_seg),  .wrap(SEC_MAX), .res(seg_dec),  .borrow(seg_brw));
   bcd_dec2 u_dec_min  (.val(dato_cr_min),  .wrap(MIN_MAX), .res(min_dec),  .borrow(min_brw));
   bcd_dec2 u_dec_hora (.val(dato_cr_hora), .wrap(HR_MAX),  .res(hora_dec), .borrow(hora_brw));

   always_comb begin
      state_nxt = state;
      seg_nxt   = dato_cr_seg;
      min_nxt   = dato_cr_min;
      hora_nxt  = dato_cr_hora;
      ld_ok     = 1'b0;

      case (sel)
         SEL_SEG:  ld_ok = EN && bcd_ok(din, SEC_MAX);
         SEL_MIN:  ld_ok = EN && bcd_ok(din, MIN_MAX);
         SEL_HORA: ld_ok = EN && bcd_ok(din, HR_MAX);
         default:  ld_ok = 1'b0;
      endcase
      ld_bad    = EN && !ld_ok;
      time_zero = (dato_cr_seg == 8'h00) && (dato_cr_min == 8'h00) && (dato_cr_hora == 8'h00);

      // Any load strobe, good or bad, swallows a coincident tick.
      dec_en = (state == ST_RUN) && tick && !EN && !time_zero;
      if (dec_en) begin
         seg_nxt = seg_dec;
         if (seg_brw) min_nxt = min_dec;
         if (seg_brw && min_brw) hora_nxt = hora_dec;
      end else if (ld_ok) begin
         case (sel)
            SEL_SEG:  seg_nxt  = din;
            SEL_MIN:  min_nxt  = din;
            default:  hora_nxt = din;
         endcase
      end
      dec_zero = dec_en && (seg_nxt == 8'h00) && (min_nxt == 8'h00) && (hora_nxt == 8'h00);

      case (state)
         ST_IDLE: if (run && !time_zero) state_nxt = ST_RUN;
         ST_RUN: begin
            if (!run)          state_nxt = ST_IDLE;
            else if (dec_zero) state_nxt = ST_DONE;
         end
         ST_DONE: if (ld_ok || !run) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase

      ring_nxt = (state != ST_DONE) && (state_nxt == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         dato_cr_seg  <= 8'h00;
         dato_cr_min  <= 8'h00;
         dato_cr_hora <= 8'h00;
         ring         <= 1'b0;
         load_err     <= 1'b0;
      end else begin
         state        <= state_nxt;
         dato_cr_seg  <= seg_nxt;
         dato_cr_min  <= min_nxt;
         dato_cr_hora <= hora_nxt;
         ring         <= ring_nxt;
         load_err     <= ld_bad;
      end
   end

   assign done = (state == ST_DONE);

endmodule

// File: tb/tb_cr_timer_reg.sv
// Directed bench for cr_timer_reg: loads, rejects, countdown, tick/load collision and reset abort.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_cr_timer_reg;

   logic       clk = 1'b0;
   logic       reset, tick, EN, run;
   logic [1:0] sel;
   logic [7:0] din;
   logic [7:0] dato_cr_seg, dato_cr_min, dato_cr_hora;
   logic       done, ring, load_err;

   int errors = 0;
   int checks = 0;
   int ring_cnt;

   always #5 clk = ~clk;

   cr_timer_reg dut (
      .clk(clk), .reset(reset), .tick(tick), .EN(EN), .sel(sel), .din(din), .run(run),
      .dato_cr_seg(dato_cr_seg), .dato_cr_min(dato_cr_min), .dato_cr_hora(dato_cr_hora),
      .done(done), .ring(ring), .load_err(load_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [1:0] s, input logic [7:0] d);
      EN = 1'b1; sel = s; din = d;
      step();
      EN = 1'b0;
   endtask

   task automatic do_tick();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   initial begin
      // Reset must win over a simultaneous load, tick and run.
      reset = 1'b1; EN = 1'b1; sel = 2'd0; din = 8'h12; tick = 1'b1; run = 1'b1;
      step();
      chk("rst_seg",  {24'h0, dato_cr_seg},  32'h00);
      chk("rst_min",  {24'h0, dato_cr_min},  32'h00);
      chk("rst_hora", {24'h0, dato_cr_hora}, 32'h00);
      chk("rst_done", {31'h0, done},         32'h0);
      chk("rst_ring", {31'h0, ring},         32'h0);
      chk("rst_lerr", {31'h0, load_err},     32'h0);
      reset = 1'b0; EN = 1'b0; tick = 1'b0; run = 1'b0;
      step();

      // 00:01:00 counted down by 60 ticks.
      load(2'd1, 8'h01);
      chk("ld_min01", {24'h0, dato_cr_min}, 32'h01);
      chk("ld_ok_noerr", {31'h0, load_err}, 32'h0);
      load(2'd0, 8'h00);
      chk("ld_seg00", {24'h0, dato_cr_seg}, 32'h00);
      run = 1'b1;
      step();
      ring_cnt = 0;
      for (int i = 1; i <= 60; i++) begin
         do_tick();
         ring_cnt += int'(ring);
         if (i == 1) begin
            chk("t1_seg", {24'h0, dato_cr_seg}, 32'h59);
            chk("t1_min", {24'h0, dato_cr_min}, 32'h00);
         end
         if (i == 50) chk("t50_seg", {24'h0, dato_cr_seg}, 32'h10);
         if (i == 60) chk("t60_ring", {31'h0, ring}, 32'h1);
         step();
         ring_cnt += int'(ring);
      end
      chk("cd_seg", {24'h0, dato_cr_seg}, 32'h00);
      chk("cd_min", {24'h0, dato_cr_min}, 32'h00);
      chk("cd_done", {31'h0, done}, 32'h1);
      do_tick();
      ring_cnt += int'(ring);
      step();
      ring_cnt += int'(ring);
      chk("ring_once", ring_cnt, 32'd1);
      chk("done_hold", {31'h0, done}, 32'h1);
      chk("done_tick_seg", {24'h0, dato_cr_seg}, 32'h00);
      run = 1'b0;
      step();
      chk("done_exit", {31'h0, done}, 32'h0);

      // Rejected loads.
      load(2'd0, 8'h25);
      chk("ld_seg25", {24'h0, dato_cr_seg}, 32'h25);
      load(2'd0, 8'h5A);
      chk("bad_nib_err", {31'h0, load_err}, 32'h1);
      chk("bad_nib_seg", {24'h0, dato_cr_seg}, 32'h25);
      step();
      chk("err_pulse", {31'h0, load_err}, 32'h0);
      load(2'd2, 8'h24);
      chk("hr24_err", {31'h0, load_err}, 32'h1);
      chk("hr24_hora", {24'h0, dato_cr_hora}, 32'h00);
      load(2'd2, 8'h23);
      chk("hr23_hora", {24'h0, dato_cr_hora}, 32'h23);
      chk("hr23_noerr", {31'h0, load_err}, 32'h0);
      load(2'd1, 8'h60);
      chk("min60_err", {31'h0, load_err}, 32'h1);
      chk("min60_min", {24'h0, dato_cr_min}, 32'h00);
      load(2'd3, 8'h11);
      chk("sel3_err", {31'h0, load_err}, 32'h1);

      // 01:00:00 -> 00:59:59 with a double borrow.
      load(2'd2, 8'h01);
      load(2'd1, 8'h00);
      load(2'd0, 8'h00);
      run = 1'b1;
      step();
      do_tick();
      chk("brw_hora", {24'h0, dato_cr_hora}, 32'h00);
      chk("brw_min",  {24'h0, dato_cr_min},  32'h59);
      chk("brw_seg",  {24'h0, dato_cr_seg},  32'h59);

      // Mid-countdown loads to 00:00:05, then load with a coincident tick.
      load(2'd1, 8'h00);
      load(2'd0, 8'h05);
      chk("mid_seg05", {24'h0, dato_cr_seg}, 32'h05);
      EN = 1'b1; sel = 2'd0; din = 8'h30; tick = 1'b1;
      step();
      EN = 1'b0; tick = 1'b0;
      chk("coll_seg", {24'h0, dato_cr_seg}, 32'h30);
      do_tick();
      chk("coll_run", {24'h0, dato_cr_seg}, 32'h29);

      // Reset aborts a countdown at 00:00:10.
      load(2'd0, 8'h10);
      reset = 1'b1; tick = 1'b1;
      step();
      reset = 1'b0; tick = 1'b0;
      chk("abort_seg",  {24'h0, dato_cr_seg}, 32'h00);
      chk("abort_done", {31'h0, done},        32'h0);
      chk("abort_ring", {31'h0, ring},        32'h0);
      do_tick();
      chk("zero_tick_seg",  {24'h0, dato_cr_seg}, 32'h00);
      chk("zero_tick_ring", {31'h0, ring},        32'h0);
      chk("zero_tick_done", {31'h0, done},        32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cr_timer_reg.md
CR_TIMER_REG -- requirements
Module: cr_timer_reg

Interface
REQ-001 The block SHALL have parameter HR_MAX, default 8'h23, meaning the largest BCD hour value accepted on load.
REQ-002 The block SHALL have parameter MIN_MAX, default 8'h59, meaning the largest BCD minute value accepted on load and the minute wrap value.
REQ-003 The block SHALL have parameter SEC_MAX, default 8'h59, meaning the largest BCD second value accepted on load and the second wrap value.
REQ-004 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port tick, input, 1 bit: one-cycle 1 Hz strobe, synchronous to clk.
REQ-007 Port EN, input, 1 bit: load strobe for the field selected by sel.
REQ-008 Port sel, input, 2 bits: field select; 0 = seconds, 1 = minutes, 2 = hours, 3 = reserved.
REQ-009 Port din, input, 8 bits: two-digit BCD load value.
REQ-010 Port run, input, 1 bit: countdown enable, level-sensitive.
REQ-011 Ports dato_cr_seg, dato_cr_min and dato_cr_hora, outputs, 8 bits each: registered BCD fields.
REQ-012 Port done, output, 1 bit: high while the timer is in state DONE.
REQ-013 Port ring, output, 1 bit: one-cycle pulse on the cycle DONE is entered.
REQ-014 Port load_err, output, 1 bit: one-cycle pulse when a load is rejected.

Function
REQ-015 The block SHALL implement states IDLE, RUN and DONE.
REQ-016 IDLE SHALL go to RUN when run=1 and the time is not 00:00:00.
REQ-017 RUN SHALL go to IDLE when run=0.
REQ-018 RUN SHALL go to DONE when a tick decrements the time to 00:00:00.
REQ-019 DONE SHALL go to IDLE on any accepted load or on run=0.
REQ-020 A load (EN=1) SHALL be accepted only if sel is not 3, both nibbles of din are <= 9, and din <= the field max. The selected field SHALL then take din on the next edge.
REQ-021 A rejected load SHALL leave all fields unchanged and pulse load_err one cycle later.
REQ-022 In RUN, each tick SHALL decrement the time by one second in BCD. Seconds 00 wraps to SEC_MAX with a borrow to minutes; minutes 00 wraps to MIN_MAX with a borrow to hours.
REQ-023 Outputs SHALL reflect a load or tick on the clock edge that samples it (latency 1 cycle, registered).
REQ-024 When EN and tick are both high in the same cycle, the load SHALL take effect and that tick SHALL be dropped.
REQ-025 A tick in IDLE or DONE, or with time 00:00:00, SHALL cause no change.
REQ-026 ring SHALL pulse exactly once per DONE entry. done SHALL remain high until DONE is exited.
REQ-027 Loads SHALL be accepted in every state, including mid-countdown.

Reset
REQ-028 While reset=1 at a clock edge, all fields SHALL become 8'h00, the state SHALL become IDLE, and done, ring and load_err SHALL become 0.
REQ-029 Reset SHALL override EN, tick and run in the same cycle, and SHALL abort a countdown or DONE mid-operation.

Structure
REQ-030 A shared package cr_pkg SHALL hold the sel codes, the state encoding and the BCD max constants.
REQ-031 One sub-module, bcd_dec2, SHALL be used: a combinational two-digit BCD decrement with wrap value input and borrow output, instantiated per field.

Verification
REQ-032 Reset, then load sel=1 din=8'h01 and sel=0 din=8'h00, run=1, then 60 ticks -> 01:00 counts to 00:00; ring pulses once, done=1.
REQ-033 Load sel=0 din=8'h5A -> load_err pulses; dato_cr_seg unchanged.
REQ-034 Load sel=2 din=8'h24 with HR_MAX=8'h23 -> rejected, load_err=1.
REQ-035 Time 01:00:00, run=1, one tick -> 00:59:59 after one cycle.
REQ-036 EN and tick in the same cycle while running at 00:00:05, loading sel=0 din=8'h30 -> seconds=8'h30, no decrement.
REQ-037 Assert reset mid-countdown at 00:00:10 -> all fields 00, state IDLE, done=0, no ring.
